mem_stage: RTL

//  Memory-access stage of the bittyCore 5-stage pipeline; sits between ex_mem and mem_wb.
//  Non-memory ops pass through unchanged. Loads and stores run a data-bus req/gnt/rvalid

---
 rtl/mem_stage_pkg.sv | 48 ++++
 rtl/mem_stage_align.sv | 62 ++++++
 rtl/mem_stage.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the bittyCore memory stage: op codes, FSM states, op classifiers.
// The misalignment classifier is only consumed when MEM_MISALIGN_CHK_EN is defined.
package mem_stage_pkg;

   typedef enum logic [3:0] {
      MEM_NONE = 4'd0,
      MEM_LB   = 4'd1,
      MEM_LH   = 4'd2,
      MEM_LW   = 4'd3,
      MEM_LBU  = 4'd4,
      MEM_LHU  = 4'd5,
      MEM_SB   = 4'd6,
      MEM_SH   = 4'd7,
      MEM_SW   = 4'd8
   } mem_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RSP  = 2'd2,
      ST_DONE = 2'd3
   } mem_state_e;

   localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

   function automatic logic is_load(input logic [3:0] op);
      case (op)
         MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU: is_load = 1'b1;
         default:                                  is_load = 1'b0;
      endcase
   endfunction

   function automatic logic is_store(input logic [3:0] op);
      case (op)
         MEM_SB, MEM_SH, MEM_SW: is_store = 1'b1;
         default:                is_store = 1'b0;
      endcase
   endfunction

   function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] addr);
      case (op)
         MEM_LH, MEM_LHU, MEM_SH: is_misaligned = addr[0];
         MEM_LW, MEM_SW:          is_misaligned = (addr != 2'b00);
         default:                 is_misaligned = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_stage_align.sv
// mem_align: byte-enable generation, store lane replication and load lane select/extend.
// Purely combinational; half accesses use addr[1] only, word accesses ignore addr[1:0].
module mem_align
   import mem_stage_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [1:0]  addr,
   input  logic [31:0] sdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] ldata
);

   logic [31:0] byte_lane;
   logic [31:0] half_lane;

   assign byte_lane = rdata >> {addr, 3'b000};
   assign half_lane = rdata >> {addr[1], 4'b0000};

   always_comb begin
      be    = 4'b0000;
      wdata = sdata;
      ldata = ZERO_WORD;
      case (op)
         MEM_SB: begin
            be    = 4'b0001 << addr;
            wdata = {4{sdata[7:0]}};
         end
         MEM_SH: begin
            be    = 4'b0011 << {addr[1], 1'b0};
            wdata = {2{sdata[15:0]}};
         end
         MEM_SW: be = 4'b1111;
         MEM_LB: begin
            be    = 4'b0001 << addr;
            ldata = {{24{byte_lane[7]}}, byte_lane[7:0]};
         end
         MEM_LBU: begin
            be    = 4'b0001 << addr;
            ldata = {24'h00_0000, byte_lane[7:0]};
         end
         MEM_LH: begin
            be    = 4'b0011 << {addr[1], 1'b0};
            ldata = {{16{half_lane[15]}}, half_lane[15:0]};
         end
         MEM_LHU: begin
            be    = 4'b0011 << {addr[1], 1'b0};
            ldata = {16'h0000, half_lane[15:0]};
         end
         MEM_LW: begin
            be    = 4'b1111;
            ldata = rdata;
         end
         default: begin
            be    = 4'b0000;
            ldata = ZERO_WORD;
         end
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// bittyCore memory-access stage: pass-through for ALU ops, req/gnt/rvalid bus handshake for loads/stores.
// Optional build macro MEM_MISALIGN_CHK_EN adds misalign_exc and suppresses misaligned accesses.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
)(
   input  logic          clk,
   input  logic          rst,
   input  logic [4:0]    mem_wd,
   input  logic          mem_wreg,
   input  logic [31:0]   mem_wdata,
   input  logic [3:0]    mem_op,
   input  logic [AW-1:0] mem_addr,
   input  logic [31:0]   mem_sdata,
   output logic [4:0]    wb_wd,
   output logic          wb_wreg,
   output logic [31:0]   wb_wdata,
   output logic          stall_req,
`ifdef MEM_MISALIGN_CHK_EN
   output logic          misalign_exc,
`endif
   output logic          dbus_req,
   output logic          dbus_we,
   output logic [AW-1:0] dbus_addr,
   output logic [3:0]    dbus_be,
   output logic [DW-1:0] dbus_wdata,
   input  logic          dbus_gnt,
   input  logic          dbus_rvalid,
   input  logic [DW-1:0] dbus_rdata
);

   mem_state_e  state;
   logic [31:0] rdata_q;
   logic        ld;
   logic        st;
   logic        mis;
   logic [3:0]  al_be;
   logic [31:0] al_wdata;
   logic [31:0] al_ldata;

   assign ld = is_load(mem_op);
   assign st = is_store(mem_op);
`ifdef MEM_MISALIGN_CHK_EN
   assign mis = is_misaligned(mem_op, mem_addr[1:0]);
`else
   assign mis = 1'b0;
`endif

   mem_align u_align (
      .op    (mem_op),
      .addr  (mem_addr[1:0]),
      .sdata (mem_sdata),
      .rdata (rdata_q),
      .be    (al_be),
      .wdata (al_wdata),
      .ldata (al_ldata)
   );

   // Access sequencer; a response arriving outside RSP never touches rdata_q.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         rdata_q <= ZERO_WORD;
      end else begin
         case (state)
            ST_IDLE: begin
               if ((ld || st) && !mis) begin
                  if (dbus_gnt) state <= st ? ST_DONE : ST_RSP;
                  else          state <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (dbus_gnt) state <= st ? ST_DONE : ST_RSP;
            end
            ST_RSP: begin
               if (dbus_rvalid) begin
                  rdata_q <= dbus_rdata;
                  state   <= ST_DONE;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Writeback, stall and bus drive; everything is held at zero while rst is high.
   always_comb begin
      wb_wd      = 5'd0;
      wb_wreg    = 1'b0;
      wb_wdata   = ZERO_WORD;
      stall_req  = 1'b0;
      dbus_req   = 1'b0;
      dbus_we    = 1'b0;
      dbus_addr  = '0;
      dbus_be    = 4'b0000;
      dbus_wdata = '0;
`ifdef MEM_MISALIGN_CHK_EN
      misalign_exc = 1'b0;
`endif
      if (!rst) begin
         wb_wd    = mem_wd;
         wb_wdata = mem_wdata;
         case (state)
            ST_IDLE: begin
               if (ld || st) begin
                  if (mis) begin
`ifdef MEM_MISALIGN_CHK_EN
                     misalign_exc = 1'b1;
`endif
                  end else begin
                     dbus_req  = 1'b1;
                     stall_req = 1'b1;
                  end
               end else begin
                  wb_wreg = mem_wreg;
               end
            end
            ST_REQ: begin
               dbus_req  = 1'b1;
               stall_req = 1'b1;
            end
            ST_RSP:  stall_req = 1'b1;
            ST_DONE: begin
               wb_wreg  = ld ? mem_wreg : 1'b0;
               wb_wdata = ld ? al_ldata : mem_wdata;
            end
            default: stall_req = 1'b0;
         endcase
         if (dbus_req) begin
            dbus_we    = st;
            dbus_addr  = {mem_addr[AW-1:2], 2'b00};
            dbus_be    = al_be;
            dbus_wdata = al_wdata;
         end else begin
            dbus_we    = 1'b0;
         end
      end else begin
         wb_wd = 5'd0;
      end
   end

endmodule
